instr_fetch: RTL and testbench

//  Instruction fetch stage: owns the PC, issues in-order word reads to instruction memory and delivers
//  {instruction, pc} over a valid/ready handshake to the decode/control stage. Accepts branch/jump

---
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC ownership, credit-limited imem reads, redirect flush
// Responses land in a small FIFO; after a redirect the stale in-flight responses are counted off in FLUSH.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FLUSH} state_t;

  state_t          r_state;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [31:0]     r_buf_instr [BUF_DEPTH];
  logic [31:0]     r_buf_pc    [BUF_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic            r_misalign;

  logic            w_redirect;
  logic [31:0]     w_target;
  logic            w_credit;
  logic            w_issue;
  logic            w_take;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_inflight;
  logic [CW-1:0]   w_discard_nxt;

  assign w_redirect    = redirect_i & (r_state != S_BOOT);
  assign w_target      = {redirect_pc_i[31:2], 2'b00};
  assign w_credit      = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CW+1)'(BUF_DEPTH);
  assign imem_req_o    = (r_state == S_FETCH) & ~redirect_i & w_credit;
  assign imem_addr_o   = r_fetch_pc;
  assign w_issue       = imem_req_o & imem_gnt_i;
  // An rvalid with nothing outstanding is a protocol error and is ignored.
  assign w_take        = imem_rvalid_i & (r_discard == '0) & (r_outstanding != '0);
  assign w_drop        = imem_rvalid_i & (r_state == S_FLUSH) & (r_discard != '0);
  assign w_push        = w_take & ~w_redirect;
  assign w_pop         = instr_valid_o & instr_ready_i;
  assign w_inflight    = r_outstanding - CW'(w_take);
  assign w_discard_nxt = r_discard - CW'(w_drop);

  assign instr_valid_o = (r_count != '0);
  assign instruction_o = r_buf_instr[r_rd_ptr];
  assign pc_o          = r_buf_pc[r_rd_ptr];
  assign misalign_o    = r_misalign;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_misalign    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc[i]    <= '0;
      end
    end else begin
      r_misalign <= w_redirect & (redirect_pc_i[1:0] != 2'b00);
      case (r_state)
        S_BOOT: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_redirect) begin
            r_fetch_pc    <= w_target;
            r_resp_pc     <= w_target;
            r_discard     <= w_inflight;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_state       <= (w_inflight != '0) ? S_FLUSH : S_FETCH;
          end else begin
            if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push) begin
              r_buf_instr[r_wr_ptr] <= imem_rdata_i;
              r_buf_pc[r_wr_ptr]    <= r_resp_pc;
              r_resp_pc             <= r_resp_pc + 32'd4;
              r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_take);
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
          end
        end
        S_FLUSH: begin
          // A second redirect only moves the target; the stale count is untouched.
          if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
          end
          r_discard <= w_discard_nxt;
          if (w_discard_nxt == '0) r_state <= S_FETCH;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch (RESET_PC=0x100, BUF_DEPTH=2)
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] rpc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        misalign;

  logic        auto_en, mon_en;
  logic        t_rv, a_rv;
  logic [31:0] t_rd, a_rd;
  logic [31:0] got_pc[$], got_ins[$], iss_addr[$];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  assign rvalid = auto_en ? a_rv : t_rv;
  assign rdata  = auto_en ? a_rd : t_rd;

  instr_fetch #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(rpc),
    .instr_valid_o(valid), .instr_ready_i(ready),
    .instruction_o(instr), .pc_o(pc), .misalign_o(misalign)
  );

  // Memory model: answers every issue one cycle later with 0xC0DE0000 ^ address.
  always @(posedge clk) begin
    a_rv <= auto_en & req & gnt;
    a_rd <= 32'hC0DE_0000 ^ addr;
  end

  always @(negedge clk) begin
    #2;
    if (mon_en && valid && ready) begin
      got_pc.push_back(pc);
      got_ins.push_back(instr);
    end
    if (mon_en && req && gnt) iss_addr.push_back(addr);
  end

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [31:0] eins;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; gnt = 0; t_rv = 0; t_rd = 0; redirect = 0; rpc = 0; ready = 0;
    auto_en = 0; mon_en = 0;
    got_pc.delete(); got_ins.delete(); iss_addr.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_misalign", {31'b0, misalign}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pcs(input int n, input int budget);
    for (int i = 0; i < budget && got_pc.size() < n; i++) @(negedge clk);
    #3;
    chk("wait_count", (got_pc.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    // gnt, rv, rdata, ready | req, addr, valid, pc, instr
    vecs[0] = '{1, 0, 32'h0,         1, 1, 32'h100, 0, 32'h0,   32'h0};
    vecs[1] = '{1, 1, 32'hC0DE_0100, 1, 1, 32'h104, 0, 32'h0,   32'h0};
    vecs[2] = '{1, 1, 32'hC0DE_0104, 1, 0, 32'h108, 1, 32'h100, 32'hC0DE_0100};
    vecs[3] = '{1, 0, 32'h0,         1, 1, 32'h108, 1, 32'h104, 32'hC0DE_0104};
    vecs[4] = '{1, 1, 32'hC0DE_0108, 1, 1, 32'h10C, 0, 32'h0,   32'h0};
    vecs[5] = '{1, 1, 32'hC0DE_010C, 1, 0, 32'h110, 1, 32'h108, 32'hC0DE_0108};
    vecs[6] = '{1, 0, 32'h0,         1, 1, 32'h110, 1, 32'h10C, 32'hC0DE_010C};

    // Streaming from RESET_PC with one-cycle memory latency
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      gnt = vecs[i].gnt; t_rv = vecs[i].rv; t_rd = vecs[i].rd; ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vecs[i].ereq});
      chk($sformatf("v%0d_addr", i), addr, vecs[i].eaddr);
      chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].evalid});
      if (vecs[i].evalid) begin
        chk($sformatf("v%0d_pc", i), pc, vecs[i].epc);
        chk($sformatf("v%0d_instr", i), instr, vecs[i].eins);
      end
    end

    // Consumer stall: credit stops requests, head holds, then drains in order
    do_reset();
    auto_en = 1; gnt = 1; ready = 0;
    begin
      logic stable;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk); #1;
        if (i >= 3 && pc !== 32'h100) stable = 1'b0;
      end
      chk("stall_hold", {31'b0, stable}, 1);
    end
    chk("stall_req", {31'b0, req}, 0);
    chk("stall_valid", {31'b0, valid}, 1);
    mon_en = 1; ready = 1;
    wait_pcs(3, 20);
    for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
      chk($sformatf("drain%0d_pc", i), got_pc[i], 32'h100 + 32'(4 * i));
      chk($sformatf("drain%0d_ins", i), got_ins[i], 32'hC0DE_0000 ^ (32'h100 + 32'(4 * i)));
    end

    // Redirect with one request outstanding: stale response dropped
    do_reset();
    @(negedge clk); gnt = 1; #1;
    chk("flush_c0_req", {31'b0, req}, 1);
    @(negedge clk); gnt = 0; redirect = 1; rpc = 32'h2000; #1;
    chk("flush_c1_req", {31'b0, req}, 0);
    @(negedge clk); redirect = 0; t_rv = 1; t_rd = 32'hDEAD_BEEF; #1;
    chk("flush_c2_req", {31'b0, req}, 0);
    @(negedge clk); t_rv = 0; gnt = 1; #1;
    chk("flush_c3_req", {31'b0, req}, 1);
    chk("flush_c3_addr", addr, 32'h2000);
    chk("flush_c3_valid", {31'b0, valid}, 0);
    @(negedge clk); gnt = 0; t_rv = 1; t_rd = 32'h1234_5678; #1;
    @(negedge clk); t_rv = 0; ready = 1; #1;
    chk("flush_c5_valid", {31'b0, valid}, 1);
    chk("flush_c5_pc", pc, 32'h2000);
    chk("flush_c5_instr", instr, 32'h1234_5678);

    // Address wrap at the top of memory
    do_reset();
    auto_en = 1; gnt = 1; ready = 1; mon_en = 1;
    @(negedge clk); redirect = 1; rpc = 32'hFFFF_FFF8; #1;
    chk("wrap_redir_req", {31'b0, req}, 0);
    @(negedge clk); redirect = 0;
    wait_pcs(3, 30);
    for (int i = 0; i < 3 && i < got_pc.size() && i < iss_addr.size(); i++) begin
      chk($sformatf("wrap%0d_addr", i), iss_addr[i], 32'hFFFF_FFF8 + 32'(4 * i));
      chk($sformatf("wrap%0d_pc", i), got_pc[i], 32'hFFFF_FFF8 + 32'(4 * i));
    end

    // Misaligned redirect target
    do_reset();
    @(negedge clk); redirect = 1; rpc = 32'h2002; #1;
    chk("mis_c0", {31'b0, misalign}, 0);
    @(negedge clk); redirect = 0; #1;
    chk("mis_c1", {31'b0, misalign}, 1);
    chk("mis_c1_req", {31'b0, req}, 1);
    chk("mis_c1_addr", addr, 32'h2000);
    @(negedge clk); #1;
    chk("mis_c2", {31'b0, misalign}, 0);

    // Asynchronous reset in the middle of FLUSH
    do_reset();
    @(negedge clk); gnt = 1;
    @(negedge clk); redirect = 1; rpc = 32'h3001;
    @(negedge clk); redirect = 0; gnt = 0; #1;
    chk("arst_pre_mis", {31'b0, misalign}, 1);
    chk("arst_pre_req", {31'b0, req}, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, req}, 0);
    chk("arst_valid", {31'b0, valid}, 0);
    chk("arst_mis", {31'b0, misalign}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("arst_req_after", {31'b0, req}, 1);
    chk("arst_addr_after", addr, 32'h100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
